shift_ram_loader: RTL and testbench

SHIFT_RAM_LOADER -- requirements
Module: shift_ram_loader

---
 rtl/shift_ram_pkg.sv | 18 +
 rtl/shift_ram_bram.sv | 44 ++++
 rtl/shift_ram_loader.sv | 146 ++++++++++++++
 tb/tb_shift_ram_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ram_pkg.sv
// Shared types and defaults for the shift_ram_loader block.
//   state_t          : loader/streamer FSM states
//   DEF_DATA_WIDTH   : default word width
//   DEF_ADDR_WIDTH   : default address width (depth = 2**ADDR_WIDTH)
package shift_ram_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 9;
  localparam int unsigned WRAP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    HOLD   = 2'd2,
    STREAM = 2'd3
  } state_t;

endpackage : shift_ram_pkg

// File: rtl/shift_ram_bram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register only updates when rd_en is high, so a stalled
// consumer sees the previous read value held.
//   clock    : rising-edge clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable (also the read-register enable)
//   rd_addr  : read address
//   rd_data  : registered read data
module shift_ram_bram
  import shift_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered, enable-gated read port
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : shift_ram_bram

// File: rtl/shift_ram_loader.sv
// Loads a burst of words into an on-chip buffer, then streams the held
// contents cyclically (0..length-1, wrap) with a valid/ready handshake.
// Optional feature macro: SHIFT_RAM_WRAP_CNT_EN adds wrap_count.
//   clock      : rising-edge clock
//   reset_n    : synchronous active-low reset
//   in_valid/in_ready/in_data/in_last : load stream
//   start      : pulse, begins streaming from HOLD
//   clear      : pulse, discards the load and returns to IDLE
//   out_valid/out_ready/out_data      : output stream (registered)
//   loaded     : a complete load is held
//   length     : number of words loaded
//   wrap_count : (macro only) completed passes over the buffer
module shift_ram_loader
  import shift_ram_pkg::*;
#(
  parameter int unsigned ID         = 1,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  start,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  loaded,
`ifdef SHIFT_RAM_WRAP_CNT_EN
  output logic [WRAP_CNT_WIDTH-1:0] wrap_count,
`endif
  output logic [ADDR_WIDTH:0]   length
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH + 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_vld;   // RAM read register holds a word
  logic                  rd_last;  // that word came from address length-1
  logic                  out_last; // out_data came from address length-1
  logic [DATA_WIDTH-1:0] rd_data;

  logic accept;
  logic advance;
  logic at_last_addr;
  logic at_full;

  // Handshake and address decode
  assign accept       = in_valid & in_ready;
  // Whole read pipeline moves together so no word is skipped or repeated
  assign advance      = (state == STREAM) & (~out_valid | out_ready);
  assign at_last_addr = ({1'b0, rd_addr} == (length - LW'(1)));
  assign at_full      = (length == LW'(DEPTH - 1));

  shift_ram_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clock   (clock),
    .wr_en   (accept),
    .wr_addr (length[ADDR_WIDTH-1:0]),
    .wr_data (in_data),
    .rd_en   (advance),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Control FSM with registered outputs; clear shares the reset path
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      loaded    <= 1'b0;
      length    <= '0;
      rd_addr   <= '0;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            length <= length + LW'(1);
            // Ends on in_last or on the word that fills the buffer
            if (in_last || at_full) begin
              state    <= HOLD;
              loaded   <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state    <= LOAD;
            end
          end
        end

        HOLD: begin
          if (start) begin
            state     <= STREAM;
            rd_addr   <= '0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end

        STREAM: begin
          if (advance) begin
            rd_addr   <= at_last_addr ? '0 : rd_addr + ADDR_WIDTH'(1);
            rd_vld    <= 1'b1;
            rd_last   <= at_last_addr;
            out_valid <= rd_vld;
            out_last  <= rd_last;
            if (rd_vld) begin
              out_data <= rd_data;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SHIFT_RAM_WRAP_CNT_EN
  // Counts transfers of the final buffer word; restarts on each start
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      wrap_count <= '0;
    end else if (state == HOLD && start) begin
      wrap_count <= '0;
    end else if (state == STREAM && out_valid && out_ready && out_last) begin
      wrap_count <= wrap_count + WRAP_CNT_WIDTH'(1);
    end
  end
`endif

endmodule : shift_ram_loader

// File: tb/tb_shift_ram_loader.sv
// Self-checking bench for shift_ram_loader: randomized loads and output
// backpressure checked against a queue model of the buffer contents.
module tb_shift_ram_loader;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 9;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          start;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          loaded;
  logic [AW:0]   length;
`ifdef SHIFT_RAM_WRAP_CNT_EN
  logic [15:0]   wrap_count;
`endif

  int errors = 0;
  int checks = 0;
  int exp_wrap = 0;
  logic [DW-1:0] ref_q[$];

  shift_ram_loader #(
    .ID         (1),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .start      (start),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .loaded     (loaded),
`ifdef SHIFT_RAM_WRAP_CNT_EN
    .wrap_count (wrap_count),
`endif
    .length     (length)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Loads n words; mode 0 random data, 1 data=index, 2 data=(index+1)*0x11
  task automatic do_load(input int n, input bit use_last, input bit gaps, input int mode);
    int i = 0;
    logic [DW-1:0] w;
    while (i < n) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL load_in_ready word %0d: got %b want 1", i, in_ready);
        end
        case (mode)
          1:       w = DW'(i);
          2:       w = DW'((i + 1) * 17);
          default: w = DW'($urandom);
        endcase
        in_valid = 1'b1;
        in_data  = w;
        in_last  = use_last && (i == n - 1);
        ref_q.push_back(w);
        i++;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expect a complete load of ref_q.size() words
  task automatic check_loaded(input string name);
    checks++;
    if (loaded !== 1'b1 || length !== (AW+1)'(ref_q.size()) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: got loaded=%b length=%0d in_ready=%b want 1 %0d 0",
               name, loaded, length, in_ready, ref_q.size());
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic pulse_start();
    start    = 1'b1;
    exp_wrap = 0;
    @(negedge clock);
    start    = 1'b0;
  endtask

  // Consumes n transfers and compares them with the cyclic model
  task automatic stream_check(input string name, input int n, input bit rnd);
    int got = 0;
    int idx = 0;
    int cyc = 0;
    bit pv = 0;
    bit pr = 0;
    bit seen = 0;
    logic [DW-1:0] pd = '0;
    while (got < n && cyc < n * 8 + 40) begin
      if (pv && !pr) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b d=%h want v=1 d=%h", name, out_valid, out_data, pd);
        end
      end
      if (!rnd && seen) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s full_rate: got out_valid=%b want 1", name, out_valid);
        end
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_data !== ref_q[idx]) begin
          errors++;
          $display("FAIL %s word %0d: got %h want %h", name, got, out_data, ref_q[idx]);
        end
        if (idx == ref_q.size() - 1) exp_wrap++;
        idx  = (idx + 1) % ref_q.size();
        got++;
        seen = 1;
      end
      pv = (out_valid === 1'b1);
      pr = out_ready;
      pd = out_data;
      @(negedge clock);
      cyc++;
    end
    out_ready = 1'b1;
    if (got < n) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: got %0d transfers want %0d", name, got, n);
    end
`ifdef SHIFT_RAM_WRAP_CNT_EN
    checks++;
    if (wrap_count !== 16'(exp_wrap)) begin
      errors++;
      $display("FAIL %s wrap_count: got %0d want %0d", name, wrap_count, exp_wrap);
    end
`endif
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || loaded !== 1'b0 || length !== '0) begin
      errors++;
      $display("FAIL %s: got in_ready=%b out_valid=%b loaded=%b length=%0d want 1 0 0 0",
               name, in_ready, out_valid, loaded, length);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check_idle("reset");
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_out_data: got %h want 0000", out_data);
    end
  endtask

  task automatic test_load3();
    ref_q.delete();
    do_load(3, 1, 0, 2);
    check_loaded("load3");
  endtask

  // in_valid while in HOLD must not write or count
  task automatic test_ignored_input();
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    in_last  = 1'b1;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_loaded("ignored_input");
  endtask

  task automatic test_stream_full();
    out_ready = 1'b1;
    pulse_start();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_c1: got out_valid=%b want 0", out_valid);
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_c2: got out_valid=%b want 0", out_valid);
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0011) begin
      errors++;
      $display("FAIL latency_first: got v=%b d=%h want v=1 d=0011", out_valid, out_data);
    end
    stream_check("stream_full", 10, 0);
  endtask

  task automatic test_backpressure();
    pulse_clear();
    ref_q.delete();
    do_load(3, 1, 0, 2);
    check_loaded("bp3_load");
    pulse_start();
    stream_check("bp3", 40, 1);
    for (int r = 0; r < 3; r++) begin
      pulse_clear();
      ref_q.delete();
      do_load(int'($urandom_range(2, 20)), 1, 1, 0);
      check_loaded("bp_rand_load");
      pulse_start();
      stream_check("bp_rand", 60, 1);
    end
  endtask

  task automatic test_len1();
    pulse_clear();
    ref_q.delete();
    do_load(1, 1, 0, 0);
    check_loaded("len1_load");
    pulse_start();
    stream_check("len1_full", 8, 0);
    pulse_clear();
    pulse_start();
    check_idle("start_after_clear");
  endtask

  task automatic test_full_depth();
    pulse_clear();
    ref_q.delete();
    do_load(1 << AW, 0, 0, 1);
    check_loaded("full_depth_load");
    pulse_start();
    stream_check("full_depth_wrap", (1 << AW) + 8, 0);
  endtask

  task automatic test_clear_start();
    pulse_clear();
    ref_q.delete();
    do_load(int'($urandom_range(3, 10)), 1, 0, 0);
    pulse_start();
    stream_check("pre_clear", 5, 1);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    start = 1'b0;
    check_idle("clear_start");
    repeat (4) @(negedge clock);
    check_idle("clear_start_after");
`ifdef SHIFT_RAM_WRAP_CNT_EN
    checks++;
    if (wrap_count !== 16'd0) begin
      errors++;
      $display("FAIL clear_wrap_count: got %0d want 0", wrap_count);
    end
`endif
  endtask

  // start in IDLE and LOAD is ignored; load continues afterwards
  task automatic test_start_ignored();
    pulse_start();
    repeat (3) @(negedge clock);
    check_idle("start_in_idle");
    ref_q.delete();
    do_load(2, 0, 0, 0);
    pulse_start();
    repeat (3) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || loaded !== 1'b0 || length !== (AW+1)'(2)) begin
      errors++;
      $display("FAIL start_in_load: got v=%b in_ready=%b loaded=%b length=%0d want 0 1 0 2",
               out_valid, in_ready, loaded, length);
    end
    do_load(1, 1, 0, 0);
    check_loaded("load_after_start");
    pulse_start();
    stream_check("stream_after_load", 6, 0);
  endtask

  task automatic test_reset_midload();
    pulse_clear();
    ref_q.delete();
    do_load(5, 0, 0, 0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_idle("reset_midload");
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_midload_out_data: got %h want 0000", out_data);
    end
    ref_q.delete();
    do_load(2, 1, 0, 0);
    check_loaded("reload2");
    pulse_start();
    stream_check("reload2_stream", 6, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_load3();
    test_ignored_input();
    test_stream_full();
    test_backpressure();
    test_len1();
    test_full_depth();
    test_clear_start();
    test_start_ignored();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift_ram_loader
